// File: rtl/track_pkg.sv
// Shared mode and route codes for the line-tracking controller and the motor driver.
package track_pkg;

  typedef enum logic [4:0] {
    ModeIdle         = 5'd0,
    ModeStart        = 5'd1,
    ModeCount        = 5'd2,
    ModeStraight     = 5'd3,
    ModeChoose       = 5'd4,
    ModeTurnStraight = 5'd5,
    ModeTurnLeft     = 5'd6,
    ModeTurnRight    = 5'd7,
    ModeStop         = 5'd30,
    ModeError        = 5'd31
  } mode_e;

  typedef enum logic [1:0] {
    RouteStraight = 2'b00,
    RouteLeft     = 2'b01,
    RouteRight    = 2'b10,
    RouteStop     = 2'b11
  } route_e;

  localparam int unsigned CntW         = 32;
  localparam int unsigned NumJunctions = 8;
  localparam logic [2:0]  SensAllBlack = 3'b111;
  localparam logic [2:0]  SensAllWhite = 3'b000;

  function automatic mode_e route_to_mode(input logic [1:0] code);
    mode_e m;
    case (code)
      RouteStraight: m = ModeTurnStraight;
      RouteLeft:     m = ModeTurnLeft;
      RouteRight:    m = ModeTurnRight;
      default:       m = ModeStop;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sensor_filter.sv
// Line-sensor conditioning: 2-flop synchronizer, plus a per-bit stability filter when
// SENSOR_DEBOUNCE_EN is defined.
module sensor_filter
  import track_pkg::*;
#(
  parameter int unsigned DEB_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sensor_i,
  output logic [2:0] sensor_o
);

  if (DEB_CYC == 0) begin : g_deb_cyc_check
    $error("DEB_CYC must be nonzero");
  end

  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sensor_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef SENSOR_DEBOUNCE_EN
  logic [2:0]      filt_q, filt_d;
  logic [CntW-1:0] deb_q [3];
  logic [CntW-1:0] deb_d [3];

  // A bit flips only after DEB_CYC consecutive samples disagreeing with the current output.
  always_comb begin
    filt_d = filt_q;
    for (int b = 0; b < 3; b++) begin
      deb_d[b] = '0;
      if (sync2_q[b] != filt_q[b]) begin
        if (deb_q[b] >= CntW'(DEB_CYC - 1)) begin
          filt_d[b] = sync2_q[b];
        end else begin
          deb_d[b] = deb_q[b] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= '0;
      for (int b = 0; b < 3; b++) deb_q[b] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int b = 0; b < 3; b++) deb_q[b] <= deb_d[b];
    end
  end

  assign sensor_o = filt_q;
`else
  assign sensor_o = sync2_q;
`endif

endmodule

// File: rtl/track_ctrl.sv
// Line-following run controller: countdown, straight tracking, route-driven junction turns.
// Build option SENSOR_DEBOUNCE_EN adds a stability filter on the sensor inputs.
module track_ctrl
  import track_pkg::*;
#(
  parameter int unsigned COUNT_CYC    = 100_000_000,
  parameter int unsigned TURN_MIN_CYC = 30_000_000,
  parameter int unsigned TURN_MAX_CYC = 200_000_000,
  parameter int unsigned LOST_CYC     = 50_000_000,
  parameter int unsigned DEB_CYC      = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [2:0]  sensor_i,
  input  logic [15:0] route_i,
  output logic [4:0]  mode_o,
  output logic [3:0]  junction_cnt_o,
  output logic        done_o
);

  if (COUNT_CYC == 0 || LOST_CYC == 0 || TURN_MAX_CYC == 0) begin : g_param_check
    $error("COUNT_CYC, LOST_CYC and TURN_MAX_CYC must be nonzero");
  end

  logic [2:0] sens;

  sensor_filter #(
    .DEB_CYC(DEB_CYC)
  ) u_sensor_filter (
    .clk     (clk),
    .rst     (rst),
    .sensor_i(sensor_i),
    .sensor_o(sens)
  );

  mode_e           state_q, state_d;
  logic [CntW-1:0] cyc_q, cyc_d;
  logic [CntW-1:0] lost_q, lost_d;
  logic [3:0]      jcnt_q, jcnt_d;
  logic            start_q, start_rise, done_q;
  logic            turn_exit;

  assign start_rise = start_i & ~start_q;
  assign turn_exit  = (cyc_q >= CntW'(TURN_MIN_CYC)) && sens[1] && (sens != SensAllBlack);

  always_comb begin
    state_d = state_q;
    jcnt_d  = jcnt_q;
    lost_d  = '0;
    case (state_q)
      ModeIdle:     if (start_rise) state_d = ModeStart;
      ModeStart: begin
        jcnt_d  = '0;
        state_d = ModeCount;
      end
      ModeCount:    if (cyc_q >= CntW'(COUNT_CYC - 1)) state_d = ModeStraight;
      ModeStraight: begin
        if (sens == SensAllBlack) begin
          state_d = ModeChoose;
        end else if (sens == SensAllWhite) begin
          if (lost_q >= CntW'(LOST_CYC - 1)) state_d = ModeError;
          else lost_d = lost_q + CntW'(1);
        end
      end
      ModeChoose: begin
        if (jcnt_q >= 4'(NumJunctions)) begin
          state_d = ModeStop;
        end else begin
          jcnt_d  = jcnt_q + 4'd1;
          state_d = route_to_mode(route_i[{jcnt_q[2:0], 1'b0} +: 2]);
        end
      end
      ModeTurnStraight: if (sens != SensAllBlack) state_d = ModeStraight;
      // Exit is checked before the timeout so a coinciding re-acquisition wins.
      ModeTurnLeft, ModeTurnRight: begin
        if (turn_exit) state_d = ModeStraight;
        else if (cyc_q >= CntW'(TURN_MAX_CYC - 1)) state_d = ModeError;
      end
      ModeStop, ModeError: if (start_rise) state_d = ModeIdle;
      default: state_d = ModeIdle;
    endcase
  end

  always_comb begin
    if (state_d != state_q) cyc_d = '0;
    else if (cyc_q != '1)   cyc_d = cyc_q + CntW'(1);
    else                    cyc_d = cyc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ModeIdle;
      cyc_q   <= '0;
      lost_q  <= '0;
      jcnt_q  <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      lost_q  <= lost_d;
      jcnt_q  <= jcnt_d;
      start_q <= start_i;
      done_q  <= (state_d == ModeStop);
    end
  end

  assign mode_o         = state_q;
  assign junction_cnt_o = jcnt_q;
  assign done_o         = done_q;

endmodule
